tone_detector: RTL

Receive-side counterpart of the pocket synth's square-wave output. Measures the rising-edge-to-rising-edge period of an incoming 1-bit audio square wave, classifies it against the four synth notes (C4 262 Hz, E4 330 Hz, G4 392 Hz, B4 494 Hz), and reports a debounced one-hot note. Used for on-board loopback self-test of the synth and as a building block for a hardware tuner.

---
 rtl/tone_detector.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tone_detector.sv
// Rising-edge period meter for a 1-bit square wave: classifies each period
// against the four synth notes and publishes a debounced one-hot note.
module tone_detector #(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned TOL_PCT  = 3,
  parameter int unsigned CONFIRM  = 3,
  localparam int unsigned MAX_PERIOD = CLK_FREQ / 200,
  localparam int unsigned PW         = $clog2(MAX_PERIOD + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          audio_in,
  output logic [3:0]    note,
  output logic          note_valid,
  output logic [PW-1:0] period,
  output logic          period_strobe
);

  localparam int unsigned P0 = 2 * (CLK_FREQ / (2 * 262));
  localparam int unsigned P1 = 2 * (CLK_FREQ / (2 * 330));
  localparam int unsigned P2 = 2 * (CLK_FREQ / (2 * 392));
  localparam int unsigned P3 = 2 * (CLK_FREQ / (2 * 494));
  localparam int unsigned W0 = P0 * TOL_PCT / 100;
  localparam int unsigned W1 = P1 * TOL_PCT / 100;
  localparam int unsigned W2 = P2 * TOL_PCT / 100;
  localparam int unsigned W3 = P3 * TOL_PCT / 100;
  localparam int unsigned MW = $clog2(CONFIRM + 1);

  localparam logic [2:0] CLS_NONE = 3'd4;

  typedef enum logic [1:0] {SILENT, ARMED, TRACK} state_t;

  state_t        state;
  logic          s1, s2, s3, rise;
  logic [PW-1:0] count;
  logic [2:0]    last_class;
  logic [MW-1:0] match_cnt;

  logic [2:0]    cls_c;
  logic [MW-1:0] match_nxt_c;
  logic [3:0]    onehot_c;

  // Synchronizer plus registered rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= audio_in;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

  function automatic logic in_band(input logic [PW-1:0] cnt, input int unsigned p,
                                   input int unsigned w);
    in_band = (32'(cnt) + w >= p) && (32'(cnt) <= p + w);
  endfunction

  // Classification of the running count; lowest note index wins on overlap
  always_comb begin
    cls_c = CLS_NONE;
    if (in_band(count, P0, W0))      cls_c = 3'd0;
    else if (in_band(count, P1, W1)) cls_c = 3'd1;
    else if (in_band(count, P2, W2)) cls_c = 3'd2;
    else if (in_band(count, P3, W3)) cls_c = 3'd3;

    if (cls_c != last_class)               match_nxt_c = MW'(1);
    else if (match_cnt >= MW'(CONFIRM))    match_nxt_c = MW'(CONFIRM);
    else                                   match_nxt_c = match_cnt + MW'(1);

    onehot_c = (cls_c == CLS_NONE) ? 4'b0000 : (4'b0001 << cls_c[1:0]);
  end

  // Measurement FSM; count is loaded with 1 on a rise so it equals the true spacing at the next rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SILENT;
      count         <= '0;
      period        <= '0;
      period_strobe <= 1'b0;
      note          <= 4'b0000;
      note_valid    <= 1'b0;
      last_class    <= CLS_NONE;
      match_cnt     <= '0;
    end else begin
      period_strobe <= 1'b0;
      unique case (state)
        SILENT: begin
          if (rise) begin
            state <= ARMED;
            count <= PW'(1);
          end
        end
        ARMED, TRACK: begin
          if (rise) begin
            state         <= TRACK;
            count         <= PW'(1);
            period        <= count;
            period_strobe <= 1'b1;
            last_class    <= cls_c;
            match_cnt     <= match_nxt_c;
            if (match_nxt_c == MW'(CONFIRM)) begin
              note       <= onehot_c;
              note_valid <= (cls_c != CLS_NONE);
            end
          end else if (count == PW'(MAX_PERIOD)) begin
            state      <= SILENT;
            note       <= 4'b0000;
            note_valid <= 1'b0;
            match_cnt  <= '0;
          end else begin
            count <= count + PW'(1);
          end
        end
        default: state <= SILENT;
      endcase
    end
  end

endmodule
